// File: rtl/serial_pkg.sv
// Shared types, error-flag indices and the baud-tick divisor helper for the serial receive path.
package serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } t_rx2_state;

    localparam int unsigned ERR_PARITY  = 0;
    localparam int unsigned ERR_FRAMING = 1;
    localparam int unsigned ERR_BREAK   = 2;

    // Main-clock cycles per oversampling tick; never below one.
    function automatic int unsigned tick_divisor(input int unsigned clk_hz,
                                                 input int unsigned baud_hz,
                                                 input int unsigned mult);
        int unsigned div;
        div = clk_hz / (baud_hz * mult);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// First-word-fall-through FIFO: head word is visible combinationally while non-empty.
module serial_rx_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic                     in_push,
    input  logic [WIDTH-1:0]         in_wdata,
    input  logic                     in_pop,
    output logic [WIDTH-1:0]         out_rdata,
    output logic                     out_full,
    output logic                     out_empty,
    output logic [$clog2(DEPTH):0]   out_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign out_full  = (count_q == FULL_LEVEL);
    assign out_empty = (count_q == '0);
    assign out_level = count_q;
    assign out_rdata = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the simultaneous push writes into.
    assign do_pop  = in_pop & ~out_empty;
    assign do_push = in_push & (~out_full | do_pop);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= in_wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/serial_async_rx_fifo.sv
// Oversampled serial receiver with FWFT receive FIFO.
// Define SERIAL_RX_MAJORITY_EN for 2-of-3 voting around each mid-bit sample.
module serial_async_rx_fifo
    import serial_pkg::*;
#(
    parameter int unsigned MAIN_CLK_HZ   = 50_000_000,
    parameter int unsigned SERIAL_CLK_HZ = 9_600,
    parameter int unsigned CLK_MULTIPLE  = 16,
    parameter int unsigned BITS          = 8,
    parameter int unsigned PARITY_BITS   = 0,
    parameter logic        EVEN_PARITY   = 1'b1,
    parameter int unsigned STOP_BITS     = 1,
    parameter logic        LOWBIT_FIRST  = 1'b1,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic                          in_enable,
    input  logic                          in_serial,
    output logic [BITS-1:0]               out_data,
    output logic [2:0]                    out_err,
    output logic                          out_valid,
    input  logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   out_level,
    output logic                          out_busy,
    output logic                          out_overflow
);
    localparam int unsigned DIV    = tick_divisor(MAIN_CLK_HZ, SERIAL_CLK_HZ, CLK_MULTIPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SUB_W  = $clog2(CLK_MULTIPLE);
    localparam int unsigned IDX_W  = $clog2(BITS);
    localparam int unsigned WORD_W = BITS + 3;
`ifdef SERIAL_RX_MAJORITY_EN
    localparam int unsigned DECIDE_AT = CLK_MULTIPLE / 2 + 1;
`else
    localparam int unsigned DECIDE_AT = CLK_MULTIPLE / 2;
`endif

    t_rx2_state       state_q, state_d;
    logic [1:0]       sync_q;
    logic             rx_s, rx_prev_q, start_det;
    logic [DIV_W-1:0] div_q;
    logic [SUB_W-1:0] sub_q;
    logic             tick, decide, bit_val;
    logic [BITS-1:0]  data_q;
    logic [IDX_W-1:0] idx_q, bit_pos;
    logic             par_q, par_err_q, frm_err_q, stop_q;
    logic             last_bit, last_stop, frm_now, is_break, push;
    logic [2:0]       flags;
    logic [WORD_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;

    assign rx_s      = sync_q[1];
    assign start_det = (state_q == StIdle) && in_enable && rx_prev_q && !rx_s;
    assign tick      = (div_q == DIV_W'(DIV - 1));
    // Sub-tick k is the tick that advances sub_q from k-1 to k.
    assign decide    = tick && (sub_q == SUB_W'(DECIDE_AT - 1));

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            sub_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], in_serial};
            rx_prev_q <= rx_s;
            div_q     <= (start_det || tick) ? '0 : div_q + 1'b1;
            if (start_det || (state_q == StBreakWait && !rx_s)) begin
                sub_q <= '0;
            end else if (tick) begin
                sub_q <= (sub_q == SUB_W'(CLK_MULTIPLE - 1)) ? '0 : sub_q + 1'b1;
            end
        end
    end

`ifdef SERIAL_RX_MAJORITY_EN
    logic [1:0] vote_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            vote_q <= 2'b11;
        end else if (tick) begin
            if (sub_q == SUB_W'(CLK_MULTIPLE / 2 - 2)) vote_q[0] <= rx_s;
            if (sub_q == SUB_W'(CLK_MULTIPLE / 2 - 1)) vote_q[1] <= rx_s;
        end
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign last_bit  = (idx_q == IDX_W'(BITS - 1));
    assign last_stop = (STOP_BITS == 1) || stop_q;
    assign bit_pos   = LOWBIT_FIRST ? idx_q : (IDX_W'(BITS - 1) - idx_q);
    assign frm_now   = frm_err_q | ~bit_val;
    assign is_break  = frm_now && (data_q == '0);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state_q <= StIdle;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (start_det) state_d = StStart;
            StStart:     if (decide) state_d = bit_val ? StIdle : StData;
            StData:      if (decide && last_bit) state_d = (PARITY_BITS != 0) ? StParity : StStop;
            StParity:    if (decide) state_d = StStop;
            StStop:      if (decide && last_stop) state_d = is_break ? StBreakWait : StIdle;
            StBreakWait: if (tick && rx_s && sub_q == SUB_W'(CLK_MULTIPLE - 1)) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        push  = (state_q == StStop) && decide && last_stop;
        flags = '0;
        flags[ERR_PARITY]  = par_err_q;
        flags[ERR_FRAMING] = frm_now;
        flags[ERR_BREAK]   = is_break;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            data_q    <= '0;
            idx_q     <= '0;
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            stop_q    <= 1'b0;
        end else if (start_det) begin
            data_q    <= '0;
            idx_q     <= '0;
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            stop_q    <= 1'b0;
        end else if (decide) begin
            case (state_q)
                StData: begin
                    data_q[bit_pos] <= bit_val;
                    par_q           <= par_q ^ bit_val;
                    idx_q           <= idx_q + 1'b1;
                end
                // Expected parity bit is the data XOR, inverted for odd sense.
                StParity: if (bit_val != (par_q ^ ~EVEN_PARITY)) par_err_q <= 1'b1;
                StStop: begin
                    if (!bit_val) frm_err_q <= 1'b1;
                    stop_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    serial_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_push   (push),
        .in_wdata  ({flags, data_q}),
        .in_pop    (out_valid & in_ready),
        .out_rdata (fifo_rdata),
        .out_full  (fifo_full),
        .out_empty (fifo_empty),
        .out_level (out_level)
    );

    assign out_valid    = ~fifo_empty;
    assign out_data     = fifo_rdata[BITS-1:0];
    assign out_err      = fifo_rdata[WORD_W-1:BITS];
    assign out_busy     = (state_q != StIdle);
    assign out_overflow = push & fifo_full & ~(out_valid & in_ready);

endmodule
